// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register file dumper.
// The state encoding is also read by the debug-unit top-level FSM when it
// reports dumper status, so the numeric values are fixed.
package regfile_dumper_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int BYTE_WIDTH      = 8;
  localparam int DEFAULT_NB_REGS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper_serializer.sv
// word_tx_serializer: captures a word on a load strobe and shifts it out one
// byte at a time, least significant byte first.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   load     capture word and restart the byte counter
//   word     DATA_WIDTH word to serialize
//   advance  current byte accepted by the consumer; move to the next one
//   tx_byte  byte currently offered (low byte of the shift register)
//   last     the byte currently offered is the final byte of the word
module word_tx_serializer
  import regfile_dumper_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  advance,
  output logic [BYTE_WIDTH-1:0] tx_byte,
  output logic                  last
);

  localparam int NB_BYTES = DATA_WIDTH / BYTE_WIDTH;
  // Keep the counter at least one bit wide even for single-byte words.
  localparam int CNT_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      byte_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (load) begin
      shift_reg    <= word;
      byte_cnt_reg <= '0;
    end else if (advance) begin
      shift_reg    <= shift_reg >> BYTE_WIDTH;
      byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
    end
  end

  assign tx_byte = shift_reg[BYTE_WIDTH-1:0];
  assign last    = (byte_cnt_reg == CNT_W'(NB_BYTES - 1));

endmodule

// File: rtl/regfile_dumper.sv
// regfile_dumper: on a start pulse, reads registers 0..NB_REGS-1 through the
// regfile debug read port and streams every word, low byte first, to the
// UART TX over a valid/ready handshake. Used to dump architectural state
// while the pipeline is halted.
//
// Ports:
//   clk         system clock
//   i_rst       synchronous active-high reset (aborts a dump, no done pulse)
//   i_start     dump request, only honoured while idle
//   o_busy      dump in progress
//   o_done      one-cycle pulse after the final byte was accepted
//   o_reg_addr  regfile debug read address
//   i_reg_data  regfile debug read data (combinational from o_reg_addr)
//   o_tx_data   byte offered to the UART TX
//   o_tx_valid  o_tx_data is valid
//   i_tx_ready  UART TX accepts the byte this cycle
//
// All outputs are decoded from registers; none depends combinationally on
// an input.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // multiple of 8
  parameter int NB_REGS    = DEFAULT_NB_REGS  // at most 32 (5-bit address)
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [REG_ADDR_WIDTH-1:0] o_reg_addr,
  input  logic [DATA_WIDTH-1:0]     i_reg_data,
  output logic [BYTE_WIDTH-1:0]     o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready
);

  localparam logic [REG_ADDR_WIDTH-1:0] LAST_ADDR = REG_ADDR_WIDTH'(NB_REGS - 1);

  dump_state_t               state_reg, state_next;
  logic [REG_ADDR_WIDTH-1:0] addr_reg, addr_next;

  logic load;
  logic advance;
  logic last_byte;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          addr_next  = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = SEND;
      end
      SEND: begin
        if (i_tx_ready && last_byte) begin
          // The address stops at the last register, so it never wraps.
          if (addr_reg == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + REG_ADDR_WIDTH'(1);
            state_next = LOAD;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The regfile read is sampled in LOAD, so a write landing on the same edge
  // is not seen: the regfile has no write-through and no bypass is added.
  assign load    = (state_reg == LOAD);
  assign advance = (state_reg == SEND) && i_tx_ready;

  word_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk     (clk),
    .rst     (i_rst),
    .load    (load),
    .word    (i_reg_data),
    .advance (advance),
    .tx_byte (o_tx_data),
    .last    (last_byte)
  );

  assign o_reg_addr = addr_reg;
  assign o_tx_valid = (state_reg == SEND);
  assign o_busy     = (state_reg != IDLE);
  assign o_done     = (state_reg == DONE);

endmodule
